// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared states, grant codes and block geometry
// for the unified main-memory fill arbiter.
package mem_arb_pkg;

  localparam int BLK_WORDS  = 8;
  localparam int WORD_IDX_W = $clog2(BLK_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    FILL_ISSUE,
    FILL_DRAIN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_I,
    GNT_D,
    GNT_ST
  } grant_t;

  // A block spans 2*words bytes; clear the in-block byte offset.
  function automatic logic [31:0] blk_base(
    input logic [31:0] addr,
    input int          words
  );
    return addr & ~(32'(2 * words) - 32'd1);
  endfunction

endpackage

// File: rtl/fill_addr_gen.sv
// fill_addr_gen: block read address sequencer for cache fills.
// CRITICAL_WORD_FIRST_EN starts at the missed word and wraps.
module fill_addr_gen #(
  parameter int ADDR_W    = 16,
  parameter int BLK_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic                         step,
  input  logic [ADDR_W-1:0]            miss_addr,
  output logic [ADDR_W-1:0]            addr,
  output logic [$clog2(BLK_WORDS)-1:0] off,
  output logic                         last
);
  import mem_arb_pkg::*;

  localparam int IW = $clog2(BLK_WORDS);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] ld_base;
  logic [IW-1:0]     ld_off;
  logic [IW-1:0]     cnt;
  logic [IW-1:0]     slot;

`ifdef CRITICAL_WORD_FIRST_EN
  assign ld_off = miss_addr[IW:1];
`else
  assign ld_off = '0;
`endif

  assign ld_base = ADDR_W'(blk_base(32'(miss_addr), BLK_WORDS));
  assign slot    = off + cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base <= '0;
      off  <= '0;
      cnt  <= '0;
      addr <= '0;
      last <= 1'b0;
    end else if (load) begin
      base <= ld_base;
      off  <= ld_off;
      cnt  <= IW'(1);
      addr <= ld_base + ADDR_W'({ld_off, 1'b0});
      last <= 1'b0;
    end else if (step) begin
      addr <= base + ADDR_W'({slot, 1'b0});
      cnt  <= cnt + IW'(1);
      last <= (cnt == IW'(BLK_WORDS - 1));
    end
  end

endmodule

// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: shares main memory between I/D fills and D stores.
// CRITICAL_WORD_FIRST_EN selects missed-word-first fill order.
module mem_fill_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BLK_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ic_miss,
  input  logic [ADDR_W-1:0]            ic_miss_addr,
  input  logic                         dc_miss,
  input  logic [ADDR_W-1:0]            dc_miss_addr,
  input  logic                         dc_wr,
  input  logic [ADDR_W-1:0]            dc_wr_addr,
  input  logic [DATA_W-1:0]            dc_wr_data,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_rvalid,
  output logic [DATA_W-1:0]            fill_data,
  output logic [$clog2(BLK_WORDS)-1:0] fill_idx,
  output logic                         ic_fill_we,
  output logic                         dc_fill_we,
  output logic                         ic_fill_done,
  output logic                         dc_fill_done,
  output logic                         dc_wr_ack,
  output logic                         busy
);
  import mem_arb_pkg::*;

  localparam int IW = $clog2(BLK_WORDS);

  state_t            state;
  grant_t            grant;
  logic [IW:0]       ret_cnt;
  logic [ADDR_W-1:0] st_addr;
  logic [ADDR_W-1:0] gen_addr;
  logic [ADDR_W-1:0] ld_addr;
  logic [IW-1:0]     gen_off;
  logic              gen_load;
  logic              gen_step;
  logic              gen_last;

  assign gen_load = (state == IDLE) && !dc_wr
                    && (dc_miss || ic_miss);
  assign ld_addr  = dc_miss ? dc_miss_addr : ic_miss_addr;
  assign gen_step = (state == FILL_ISSUE) && !gen_last;
  assign mem_addr = (grant == GNT_ST) ? st_addr : gen_addr;
  assign busy     = (state != IDLE);

  fill_addr_gen #(
    .ADDR_W    (ADDR_W),
    .BLK_WORDS (BLK_WORDS)
  ) u_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (gen_load),
    .step      (gen_step),
    .miss_addr (ld_addr),
    .addr      (gen_addr),
    .off       (gen_off),
    .last      (gen_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant        <= GNT_NONE;
      ret_cnt      <= '0;
      st_addr      <= '0;
      mem_en       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_wdata    <= '0;
      fill_data    <= '0;
      fill_idx     <= '0;
      ic_fill_we   <= 1'b0;
      dc_fill_we   <= 1'b0;
      ic_fill_done <= 1'b0;
      dc_fill_done <= 1'b0;
      dc_wr_ack    <= 1'b0;
    end else begin
      ic_fill_we   <= 1'b0;
      dc_fill_we   <= 1'b0;
      ic_fill_done <= 1'b0;
      dc_fill_done <= 1'b0;
      dc_wr_ack    <= 1'b0;
      unique case (state)
        IDLE: begin
          ret_cnt <= '0;
          if (dc_wr) begin
            grant     <= GNT_ST;
            st_addr   <= dc_wr_addr;
            mem_wdata <= dc_wr_data;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b1;
            dc_wr_ack <= 1'b1;
            state     <= STORE;
          end else if (dc_miss || ic_miss) begin
            grant  <= dc_miss ? GNT_D : GNT_I;
            mem_en <= 1'b1;
            mem_wr <= 1'b0;
            state  <= FILL_ISSUE;
          end
        end
        STORE: begin
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          state  <= IDLE;
        end
        FILL_ISSUE, FILL_DRAIN: begin
          if (state == FILL_ISSUE && gen_last) begin
            mem_en <= 1'b0;
            state  <= FILL_DRAIN;
          end
          // Whole block written last cycle: pulse done now.
          if (ret_cnt == (IW+1)'(BLK_WORDS)) begin
            state        <= DONE;
            ic_fill_done <= (grant == GNT_I);
            dc_fill_done <= (grant == GNT_D);
          end else if (mem_rvalid) begin
            fill_data  <= mem_rdata;
            fill_idx   <= gen_off + ret_cnt[IW-1:0];
            ic_fill_we <= (grant == GNT_I);
            dc_fill_we <= (grant == GNT_D);
            ret_cnt    <= ret_cnt + (IW+1)'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb_mem_fill_arbiter: directed and randomized fills/stores against
// a 4-cycle pipelined memory model and a block-order reference model.
module tb_mem_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_miss, dc_miss, dc_wr;
  logic [15:0] ic_miss_addr, dc_miss_addr, dc_wr_addr, dc_wr_data;
  logic        mem_en, mem_wr, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic [2:0]  fill_idx;
  logic        ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done;
  logic        dc_wr_ack, busy;

  always #5 clk = ~clk;

  mem_fill_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
    .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr),
    .dc_wr(dc_wr), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .fill_data(fill_data),
    .fill_idx(fill_idx), .ic_fill_we(ic_fill_we),
    .dc_fill_we(dc_fill_we), .ic_fill_done(ic_fill_done),
    .dc_fill_done(dc_fill_done), .dc_wr_ack(dc_wr_ack), .busy(busy)
  );

  int compares = 0;
  int errs     = 0;
  int cyc      = 0;
  logic [15:0] salt;

  logic [15:0] pend_addr [8];
  bit          pend_v    [8];

  logic [15:0] rd_q[$];  int rd_c[$];
  logic [15:0] wra_q[$]; logic [15:0] wrd_q[$]; int wr_c[$];
  logic [2:0]  icx_q[$]; logic [15:0] icd_q[$]; int icw_c[$];
  logic [2:0]  dcx_q[$]; logic [15:0] dcd_q[$]; int dcw_c[$];
  int icdn_c[$], dcdn_c[$], ack_c[$];

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ salt;
  endfunction

  function automatic logic [63:0] outs();
    return {5'd0, mem_en, mem_wr, mem_addr, mem_wdata, fill_data,
            fill_idx, ic_fill_we, dc_fill_we, ic_fill_done,
            dc_fill_done, dc_wr_ack, busy};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compares++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model and bus monitor, one cycle = #1 after each edge.
  initial begin
    for (int i = 0; i < 8; i++) pend_v[i] = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      mem_rvalid = pend_v[cyc % 8];
      mem_rdata  = pend_v[cyc % 8] ? memfn(pend_addr[cyc % 8]) : 16'h0;
      pend_v[cyc % 8] = 1'b0;
      if (mem_en && !mem_wr) begin
        pend_v[(cyc + 4) % 8]    = 1'b1;
        pend_addr[(cyc + 4) % 8] = mem_addr;
        rd_q.push_back(mem_addr); rd_c.push_back(cyc);
      end
      if (mem_en && mem_wr) begin
        wra_q.push_back(mem_addr); wrd_q.push_back(mem_wdata);
        wr_c.push_back(cyc);
      end
      if (ic_fill_we) begin
        icx_q.push_back(fill_idx); icd_q.push_back(fill_data);
        icw_c.push_back(cyc);
      end
      if (dc_fill_we) begin
        dcx_q.push_back(fill_idx); dcd_q.push_back(fill_data);
        dcw_c.push_back(cyc);
      end
      if (ic_fill_we || dc_fill_we)
        chk("we_excl", 64'(ic_fill_we & dc_fill_we), 64'd0);
      if (ic_fill_done) icdn_c.push_back(cyc);
      if (dc_fill_done) dcdn_c.push_back(cyc);
      if (dc_wr_ack)    ack_c.push_back(cyc);
    end
  end

  task automatic clear_logs();
    rd_q.delete();  rd_c.delete();
    wra_q.delete(); wrd_q.delete(); wr_c.delete();
    icx_q.delete(); icd_q.delete(); icw_c.delete();
    dcx_q.delete(); dcd_q.delete(); dcw_c.delete();
    icdn_c.delete(); dcdn_c.delete(); ack_c.delete();
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_done(input bit is_d, output int dcyc);
    dcyc = -1;
    for (int n = 0; n < 60; n++) begin
      step();
      if (is_d ? dc_fill_done : ic_fill_done) begin
        dcyc = cyc;
        return;
      end
    end
    chk(is_d ? "dc_done_timeout" : "ic_done_timeout",
        64'(is_d ? dc_fill_done : ic_fill_done), 64'd1);
  endtask

  // Expected block order from the miss address alone.
  task automatic check_fill(input string tag, input bit is_d,
                            input logic [15:0] a, input int rs,
                            input int dcyc);
    logic [15:0] base, ea;
    int off, nw, lastw;
    base = a & 16'hFFF0;
`ifdef CRITICAL_WORD_FIRST_EN
    off = int'(a[3:1]);
`else
    off = 0;
`endif
    nw = is_d ? dcx_q.size() : icx_q.size();
    chk({tag, "_nrd"}, 64'(rd_q.size() >= rs + 8), 64'd1);
    chk({tag, "_nwe"}, 64'(nw), 64'd8);
    if (rd_q.size() < rs + 8 || nw < 8) return;
    for (int i = 0; i < 8; i++) begin
      ea = base + 16'(2 * ((off + i) % 8));
      chk($sformatf("%s_rd%0d", tag, i), 64'(rd_q[rs + i]), 64'(ea));
      chk($sformatf("%s_idx%0d", tag, i),
          64'(is_d ? dcx_q[i] : icx_q[i]), 64'((off + i) % 8));
      chk($sformatf("%s_dat%0d", tag, i),
          64'(is_d ? dcd_q[i] : icd_q[i]), 64'(memfn(ea)));
    end
    lastw = is_d ? dcw_c[7] : icw_c[7];
    chk({tag, "_burst"}, 64'(rd_c[rs + 7] - rd_c[rs]), 64'd7);
    chk({tag, "_lat"}, 64'(lastw - rd_c[rs]), 64'd12);
    chk({tag, "_done_lat"}, 64'(dcyc - lastw), 64'd1);
  endtask

  task automatic check_busy_tail(input string tag);
    chk({tag, "_busy_done"}, 64'(busy), 64'd1);
    step();
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int d1, d2, rv, stray;
    logic [15:0] a;
    bit is_d;
    rst_n = 1'b0; ic_miss = 1'b0; dc_miss = 1'b0; dc_wr = 1'b0;
    ic_miss_addr = '0; dc_miss_addr = '0;
    dc_wr_addr = '0; dc_wr_data = '0;
    salt = 16'h3C5A;
    repeat (3) step();
    chk("reset_outs", outs(), 64'd0);
    rst_n = 1'b1;
    step();

    // I miss at 0x0046.
    clear_logs();
    ic_miss_addr = 16'h0046; ic_miss = 1'b1;
    wait_done(1'b0, d1);
    ic_miss = 1'b0;
    check_fill("i46", 1'b0, 16'h0046, 0, d1);
    chk("i46_no_dwe", 64'(dcx_q.size()), 64'd0);
    chk("i46_ndone", 64'(icdn_c.size()), 64'd1);
    chk("i46_nowr", 64'(wra_q.size()), 64'd0);
    check_busy_tail("i46");
    step();

    // D and I together: D wins, I starts right after.
    clear_logs();
    salt = 16'(($urandom));
    dc_miss_addr = 16'h1000; ic_miss_addr = 16'h2000;
    dc_miss = 1'b1; ic_miss = 1'b1;
    wait_done(1'b1, d1);
    dc_miss = 1'b0;
    check_fill("d1000", 1'b1, 16'h1000, 0, d1);
    chk("d1000_no_iwe", 64'(icx_q.size()), 64'd0);
    check_busy_tail("d1000");
    wait_done(1'b0, d2);
    ic_miss = 1'b0;
    check_fill("i2000", 1'b0, 16'h2000, 8, d2);
    chk("i2000_start", 64'(rd_c.size() > 8 ? rd_c[8] : 0), 64'(d1 + 2));
    step(); step();

    // Store raised mid-fill waits for the fill to finish.
    clear_logs();
    a = 16'($urandom);
    ic_miss_addr = a; ic_miss = 1'b1;
    repeat (3) step();
    dc_wr_addr = 16'h0100; dc_wr_data = 16'hBEEF; dc_wr = 1'b1;
    wait_done(1'b0, d1);
    ic_miss = 1'b0;
    chk("st_nowr_before", 64'(wra_q.size()), 64'd0);
    check_fill("ist", 1'b0, a, 0, d1);
    for (int n = 0; n < 10 && !dc_wr_ack; n++) step();
    chk("st_ack", 64'(dc_wr_ack), 64'd1);
    dc_wr = 1'b0;
    step(); step();
    chk("st_nwr", 64'(wra_q.size()), 64'd1);
    chk("st_addr", 64'(wra_q.size() ? wra_q[0] : 0), 64'h0100);
    chk("st_data", 64'(wrd_q.size() ? wrd_q[0] : 0), 64'hBEEF);
    chk("st_cyc", 64'(wr_c.size() ? wr_c[0] : 0), 64'(d1 + 2));
    chk("st_ack_cyc", 64'(ack_c.size() ? ack_c[0] : -1),
        64'(wr_c.size() ? wr_c[0] : 0));
    chk("st_nack", 64'(ack_c.size()), 64'd1);

    // D miss at 0x00AA (critical word 5 when enabled).
    clear_logs();
    dc_miss_addr = 16'h00AA; dc_miss = 1'b1;
    wait_done(1'b1, d1);
    dc_miss = 1'b0;
    check_fill("daa", 1'b1, 16'h00AA, 0, d1);
    step(); step();

    // Reset on the third return abandons the fill.
    clear_logs();
    ic_miss_addr = 16'($urandom); ic_miss = 1'b1;
    rv = 0;
    for (int n = 0; n < 40 && rv < 3; n++) begin
      step();
      if (mem_rvalid) rv++;
    end
    chk("rst_third_ret", 64'(rv), 64'd3);
    rst_n = 1'b0; ic_miss = 1'b0;
    step();
    chk("rst_mid_outs", outs(), 64'd0);
    rst_n = 1'b1;
    clear_logs();
    stray = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (mem_rvalid) stray++;
    end
    chk("rst_stray_seen", 64'(stray > 0), 64'd1);
    chk("rst_no_iwe", 64'(icx_q.size() + dcx_q.size()), 64'd0);
    chk("rst_no_done", 64'(icdn_c.size() + dcdn_c.size()), 64'd0);
    chk("rst_no_rd", 64'(rd_q.size()), 64'd0);

    // Top-of-memory block.
    clear_logs();
    dc_miss_addr = 16'hFFF2; dc_miss = 1'b1;
    wait_done(1'b1, d1);
    dc_miss = 1'b0;
    check_fill("dfff2", 1'b1, 16'hFFF2, 0, d1);
    check_busy_tail("dfff2");
    step();

    // Randomized single fills.
    for (int k = 0; k < 4; k++) begin
      clear_logs();
      salt = 16'($urandom);
      is_d = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      if (is_d) begin dc_miss_addr = a; dc_miss = 1'b1; end
      else begin ic_miss_addr = a; ic_miss = 1'b1; end
      wait_done(is_d, d1);
      dc_miss = 1'b0; ic_miss = 1'b0;
      check_fill($sformatf("rnd%0d", k), is_d, a, 0, d1);
      chk($sformatf("rnd%0d_other", k),
          64'(is_d ? icx_q.size() : dcx_q.size()), 64'd0);
      check_busy_tail($sformatf("rnd%0d", k));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compares, errs);
    $finish;
  end

endmodule
